fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction fetch stage that sits directly upstream of the single-cycle datapath and produces the Instr word that stage consumes. It owns the PC register and issues word fetches to instruction memory over a request/grant/response handshake. Returned words go into a small in-order buffer and are presented to the decode/datapath side with a valid/ready handshake. Redirects from branch/jump resolution flush the buffer and discard stale in-flight responses.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset
FIFO_DEPTH, 2, instruction buffer entries; also the credit limit on in-flight plus buffered fetches (min 1)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous, active-high
imem_req  output  1  fetch request valid
imem_addr  output  32  fetch byte address, word aligned
imem_gnt  input  1  memory accepts request this cycle
imem_rvalid  input  1  response valid; in order; at least 1 cycle after grant
imem_rdata  input  32  fetched instruction word
redirect_valid  input  1  PC redirect (taken branch/jump)
redirect_pc  input  32  redirect target; bits [1:0] ignored and forced to 0
instr_valid  output  1  buffer head valid
instr  output  32  instruction word to datapath Instr
instr_pc  output  32  PC of instr
instr_ready  input  1  consumer accepts head this cycle

Behaviour:
- Clocking: one clock domain, clk. reset is synchronous and active-high. On a reset cycle: fetch_pc<=RESET_PC, buffer emptied, outstanding<=0, discard<=0.
- During reset and the first cycle after it: imem_req=0, instr_valid=0. imem_addr=fetch_pc at all times.
- Credit rule: used = count + outstanding - pop, where pop = instr_valid && instr_ready.
- imem_req=1 iff used < FIFO_DEPTH, no redirect_valid this cycle, and not in reset.
- Grant: a grant (imem_req && imem_gnt) increments outstanding and sets fetch_pc<=fetch_pc+4, with 32-bit wrap.
- Hold rule: while imem_req=1 and no grant, imem_addr stays stable. A redirect may withdraw the request; memory captures only on grant.
- Response handling: imem_rvalid decrements outstanding.
- If discard>0, the response is dropped and discard is decremented.
- Otherwise {pc, instr} is pushed into the buffer. The pc comes from a resp_pc register that advances by 4 per accepted response.
- Latency: grant in cycle N and rvalid in cycle N+k (k>=1) give instr_valid in cycle N+k+1 (registered buffer, no bypass).
- Throughput: with FIFO_DEPTH=2, k=1, and instr_ready held high, one instruction per cycle is sustained.
- Output: instr/instr_pc show the buffer head when instr_valid=1. Values are don't-care when instr_valid=0.
- Redirect cycle actions:
  - Buffer flushed; any pop in the same cycle is void.
  - fetch_pc<=redirect_pc & ~3 and resp_pc<=same value.
  - discard<=discard + outstanding - (rvalid this cycle ? 1 : 0).
  - A response arriving in the redirect cycle is dropped.
  - No request is issued in that cycle; next-cycle fetch uses the new target.
- Back-to-back redirects: the last one wins. discard accumulates correctly and never underflows.
- Simultaneous push and pop on a full buffer is legal. Credits prevent push-when-full, so overflow must be impossible: assert it.
- Reset mid-operation: all state is cleared. Responses to requests granted before reset are a system error (memory is reset too) and are not handled.
- rvalid with outstanding==0 is illegal: assert it.

Decomposition:
- Package fetch_pkg:
  - XLEN=32
  - RESET_PC_DEFAULT
  - typedef fetch_entry_t {logic [31:0] pc; logic [31:0] instr;}
  - INSTR_NOP=32'h0000_0013
- Sub-module fetch_fifo: synchronous FIFO of fetch_entry_t, parameter DEPTH, ports push/pop/flush/full/empty/count, flush having priority over push.
- Top level holds fetch_pc, resp_pc, outstanding/discard counters, and credit logic.

Test Plan:
1. Reset, then release: cycle after release imem_req=0; next cycle imem_req=1, imem_addr=0x0; instr_valid stays 0 until the first response has been buffered.
2. Memory model with k=1, gnt=1, returning 0x00500093 at 0x0 and 0xFFE08113 at 0x4, instr_ready=1: instr_valid=1 on consecutive cycles with instr_pc 0x0 then 0x4 and matching words; no gaps afterwards.
3. Grant stall: hold gnt=0 for 3 cycles at addr 0x8: imem_addr stays 0x8 and imem_req stays 1; after the grant, the next address is 0xC.
4. Backpressure with instr_ready=0: at most 2 grants, after which imem_req=0; buffer holds 0x0 and 0x4; raising ready pops them in order and fetching resumes at 0x8.
5. Redirect to 0x103 while 2 fetches are in flight (k=3): both stale responses are dropped; the first instr_valid has instr_pc=0x100; buffer count never exceeds 2.
6. Assert reset during streaming: next cycle instr_valid=0, imem_req=0; refetch starts at RESET_PC; overflow/underflow assertions never fire.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int XLEN = 32;

    // PC the fetch stage starts from after reset unless overridden.
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // addi x0, x0, 0 -- presented on instr while the buffer is empty.
    localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

    // One buffered fetch result: the word and the PC it was fetched from.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small in-order buffer of fetch results. Flush beats push and pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  fetch_entry_t       push_data,
    input  logic               pop,
    input  logic               flush,
    output fetch_entry_t       head,
    output logic               full,
    output logic               empty,
    output logic [CNT_W-1:0]   count
);

    localparam int               PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST  = PTR_W'(DEPTH - 1);

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    // Next pointers, count and storage contents; flush empties the buffer outright.
    always_comb begin
        // NOTE: every signal written here gets its default first, so no path can leave it unassigned and infer a latch.
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        do_push  = push && !flush;
        do_pop   = pop && !flush && !empty;

        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; count and pointers alone define which entries are valid.
        mem_q <= mem_d;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues credit-limited word fetches,
// buffers responses in order and drops stale responses after a redirect.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            instr_ready
);

    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int USED_W = CNT_W + 1;

    logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]   resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0]  outstanding_q, outstanding_d;
    logic [CNT_W-1:0]  discard_q, discard_d;
    logic              started_q, started_d;

    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full, fifo_empty;
    fetch_entry_t      fifo_head, push_entry;
    logic [USED_W-1:0] used;
    logic [XLEN-1:0]   target;
    logic              pop, push, grant;

    // started_q keeps the request low for the first cycle after reset.
    assign instr_valid = !fifo_empty && !reset;
    assign pop         = instr_valid && instr_ready;
    assign used        = USED_W'(fifo_count) + USED_W'(outstanding_q) - USED_W'(pop);
    assign imem_req    = started_q && !reset && !redirect_valid && (used < USED_W'(FIFO_DEPTH));
    assign grant       = imem_req && imem_gnt;
    assign push        = imem_rvalid && !redirect_valid && (discard_q == '0);
    assign imem_addr   = fetch_pc_q;
    assign target      = redirect_pc & ~32'd3;
    assign push_entry  = '{pc: resp_pc_q, instr: imem_rdata};
    assign instr       = instr_valid ? fifo_head.instr : INSTR_NOP;
    assign instr_pc    = fifo_head.pc;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (redirect_valid),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Next PC, response PC and in-flight bookkeeping.
    always_comb begin
        started_d     = 1'b1;
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        discard_d     = discard_q;
        outstanding_d = outstanding_q + CNT_W'(grant) - CNT_W'(imem_rvalid);

        if (grant) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
        if (push) begin
            resp_pc_d = resp_pc_q + 32'd4;
        end
        if (imem_rvalid && (discard_q != '0)) begin
            discard_d = discard_q - CNT_W'(1);
        end

        // outstanding_q counts stale and live requests alike, so after a redirect
        // everything still in flight (less this cycle's response) is stale: this is
        // the old discard count plus the live in-flight requests.
        if (redirect_valid) begin
            fetch_pc_d = target;
            resp_pc_d  = target;
            discard_d  = outstanding_q - CNT_W'(imem_rvalid);
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            started_q     <= 1'b0;
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            started_q     <= started_d;
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    // The credit rule must make a push into a full buffer impossible.
    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        (push && fifo_full) |-> pop);

    // Memory never answers a request that was not granted.
    a_no_orphan_rvalid: assert property (@(posedge clk) disable iff (reset)
        imem_rvalid |-> (outstanding_q != '0));

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by random
// grant/latency/backpressure/redirect/reset traffic against a queue-based model.
module tb_fetch_unit;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b0;

    fetch_unit #(
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready)
    );

    always #5 clk = ~clk;

    // Reference model state: requests in flight at the memory (oldest first),
    // words the consumer should see next, and the address the next grant fetches.
    typedef struct { logic [31:0] addr; int due; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] word; } ent_t;

    req_t        inflight[$];
    ent_t        exp_buf[$];
    int          n_stale = 0;
    logic [31:0] exp_fetch = RESET_PC;
    bit          post_rst = 1'b0;
    int          cyc = 0;
    int          lat_min = 1;
    int          lat_max = 1;

    int total = 0;
    int bad   = 0;

    bit          last_req, last_valid, last_grant;
    logic [31:0] last_addr, last_pc, last_instr, last_grant_addr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        if (a == 32'h4) return 32'hFFE0_8113;
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    // One clock cycle: drive inputs after the falling edge, sample outputs 1 time unit later,
    // compare with the model and advance the model to the state after the next rising edge.
    task automatic run_cycle(input bit rst, input bit gnt, input bit rdy, input bit redir,
                             input logic [31:0] rpc);
        bit   rv, exp_valid, exp_req, pop, grant;
        req_t r;
        ent_t e;
        @(negedge clk);
        reset          = rst;
        imem_gnt       = gnt;
        instr_ready    = rdy;
        redirect_valid = redir && !rst;
        redirect_pc    = rpc;
        rv             = !rst && (inflight.size() != 0) && (inflight[0].due <= cyc);
        imem_rvalid    = rv;
        imem_rdata     = rv ? mem_word(inflight[0].addr) : $urandom;
        #1;
        grant = 1'b0;
        if (rst) begin
            check("reset_req", imem_req, 0);
            check("reset_valid", instr_valid, 0);
            inflight.delete();
            exp_buf.delete();
            n_stale   = 0;
            exp_fetch = RESET_PC;
            post_rst  = 1'b1;
        end else begin
            exp_valid = (exp_buf.size() != 0);
            pop       = exp_valid && rdy;
            exp_req   = !post_rst && !redir &&
                        ((inflight.size() + exp_buf.size() - int'(pop)) < DEPTH);
            check("imem_req", imem_req, exp_req);
            check("instr_valid", instr_valid, exp_valid);
            check("imem_addr", imem_addr, exp_fetch);
            if (exp_valid && instr_valid) begin
                check("instr_pc", instr_pc, exp_buf[0].pc);
                check("instr", instr, exp_buf[0].word);
            end
            grant = imem_req && gnt;

            if (pop && !redir) void'(exp_buf.pop_front());
            if (rv) begin
                r = inflight.pop_front();
                if (n_stale > 0) n_stale--;
                else if (!redir) begin
                    e.pc   = r.addr;
                    e.word = mem_word(r.addr);
                    exp_buf.push_back(e);
                end
            end
            if (redir) begin
                exp_buf.delete();
                n_stale   = inflight.size();
                exp_fetch = rpc & ~32'd3;
            end
            if (grant) begin
                r.addr = exp_fetch;
                r.due  = cyc + int'($urandom_range(lat_max, lat_min));
                inflight.push_back(r);
                exp_fetch = exp_fetch + 32'd4;
            end
            check("occupancy_le_depth", 32'((inflight.size() + exp_buf.size()) <= DEPTH), 1);
            post_rst = 1'b0;
        end
        last_req        = imem_req;
        last_addr       = imem_addr;
        last_valid      = instr_valid;
        last_pc         = instr_pc;
        last_instr      = instr;
        last_grant      = grant;
        last_grant_addr = imem_addr;
        cyc++;
    endtask

    task automatic do_reset();
        run_cycle(1, 0, 0, 0, 0);
        run_cycle(1, 0, 0, 0, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] vpcs[$];
        logic [31:0] vwords[$];
        logic [31:0] first_addr;
        int          gaps, grants;
        bit          found;

        // Reset release, then streaming with one-cycle latency and the consumer always ready.
        lat_min = 1; lat_max = 1;
        do_reset();
        run_cycle(0, 1, 1, 0, 0);
        check("t1_req_first_cycle", last_req, 0);
        run_cycle(0, 1, 1, 0, 0);
        check("t1_req_second_cycle", last_req, 1);
        check("t1_addr_second_cycle", last_addr, 32'h0);
        gaps = 0;
        for (int i = 0; i < 12; i++) begin
            run_cycle(0, 1, 1, 0, 0);
            if (last_valid) begin
                vpcs.push_back(last_pc);
                vwords.push_back(last_instr);
            end else if (vpcs.size() != 0) gaps++;
        end
        check("t2_valid_count", vpcs.size(), 11);
        check("t2_gaps", gaps, 0);
        if (vpcs.size() >= 2) begin
            check("t2_pc0", vpcs[0], 32'h0);
            check("t2_word0", vwords[0], 32'h0050_0093);
            check("t2_pc1", vpcs[1], 32'h4);
            check("t2_word1", vwords[1], 32'hFFE0_8113);
        end

        // Grant stall at 0x8: address and request must hold until granted.
        do_reset();
        run_cycle(0, 1, 1, 0, 0);
        run_cycle(0, 1, 1, 0, 0);
        run_cycle(0, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            run_cycle(0, 0, 1, 0, 0);
            check("t3_stall_req", last_req, 1);
            check("t3_stall_addr", last_addr, 32'h8);
        end
        run_cycle(0, 1, 1, 0, 0);
        check("t3_grant", last_grant, 1);
        check("t3_grant_addr", last_grant_addr, 32'h8);
        run_cycle(0, 1, 1, 0, 0);
        check("t3_next_addr", last_addr, 32'hC);

        // Backpressure: two fetches fill the credit, then ready drains them in order.
        do_reset();
        grants = 0;
        for (int i = 0; i < 8; i++) begin
            run_cycle(0, 1, 0, 0, 0);
            if (last_grant) grants++;
        end
        check("t4_grants", grants, 2);
        check("t4_req_blocked", last_req, 0);
        vpcs.delete();
        first_addr = 32'hDEAD_BEEF;
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            run_cycle(0, 1, 1, 0, 0);
            if (last_valid) vpcs.push_back(last_pc);
            if (last_grant && !found) begin
                first_addr = last_grant_addr;
                found = 1'b1;
            end
        end
        check("t4_resume_addr", first_addr, 32'h8);
        check("t4_pop_count_ge2", 32'(vpcs.size() >= 2), 1);
        if (vpcs.size() >= 2) begin
            check("t4_pop0", vpcs[0], 32'h0);
            check("t4_pop1", vpcs[1], 32'h4);
        end

        // Redirect to 0x103 with two fetches in flight at latency 3.
        lat_min = 3; lat_max = 3;
        do_reset();
        grants = 0;
        for (int i = 0; i < 3; i++) begin
            run_cycle(0, 1, 1, 0, 0);
            if (last_grant) grants++;
        end
        check("t5_inflight_before_redirect", grants, 2);
        run_cycle(0, 1, 1, 1, 32'h0000_0103);
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            run_cycle(0, 1, 1, 0, 0);
            if (last_valid) begin
                found = 1'b1;
                check("t5_first_pc", last_pc, 32'h100);
                check("t5_first_word", last_instr, mem_word(32'h100));
            end
        end
        check("t5_first_valid_seen", found, 1);

        // Reset in the middle of streaming: fetch restarts from RESET_PC.
        lat_min = 1; lat_max = 2;
        do_reset();
        for (int i = 0; i < 40; i++)
            run_cycle(0, ($urandom_range(3, 0) != 0), ($urandom_range(3, 0) != 0), 0, 0);
        run_cycle(1, 1, 1, 0, 0);
        run_cycle(0, 1, 1, 0, 0);
        check("t6_valid_after_reset", last_valid, 0);
        check("t6_req_after_reset", last_req, 0);
        found = 1'b0;
        first_addr = 32'hDEAD_BEEF;
        for (int i = 0; i < 10 && !found; i++) begin
            run_cycle(0, 1, 1, 0, 0);
            if (last_grant) begin
                found = 1'b1;
                first_addr = last_grant_addr;
            end
        end
        check("t6_refetch_addr", first_addr, RESET_PC);

        // Random traffic: grant stalls, latency 1..4, backpressure, redirects, occasional reset.
        lat_min = 1; lat_max = 4;
        for (int i = 0; i < 2000; i++) begin
            run_cycle(($urandom_range(199, 0) == 0),
                      ($urandom_range(9, 0) < 7),
                      ($urandom_range(9, 0) < 6),
                      ($urandom_range(99, 0) < 3),
                      $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
